multi_signal_tracker: RTL and testbench

N-channel successor to signal_tracker. Each channel timestamps active pulses on its tracked signal against the shared signed time base `counter`. It also range-checks a per-channel value across the pulse. Completed pulse records go into one shared FIFO drained through a valid/ready port by the trace packer.

---
 rtl/multi_signal_tracker.sv | 191 +++++++++++++++++++
 tb/tb_multi_signal_tracker.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_signal_tracker.sv
// multi_signal_tracker: timestamps per-channel pulses against a shared signed
// time base, range-checks a per-channel value across each pulse, and queues
// completed pulse records into one shared FIFO with a valid/ready output.
//
// state  | meaning
// IDLE   | waiting for the start edge at the current polarity setting
// ACTIVE | pulse in progress; polarity latched, accumulating the range check
module multi_signal_tracker #(
    parameter int NUM_CHANNELS = 4,
    parameter int TIME_WIDTH   = 32,
    parameter int VALUE_WIDTH  = 32,
    parameter int FIFO_DEPTH   = 4,
    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic signed [TIME_WIDTH-1:0]        counter,
    input  logic [NUM_CHANNELS-1:0]             tracked_signal,
    input  logic [NUM_CHANNELS-1:0]             polarity,
    input  logic [NUM_CHANNELS*VALUE_WIDTH-1:0] value_in,
    input  logic [VALUE_WIDTH-1:0]              range_lo,
    input  logic [VALUE_WIDTH-1:0]              range_hi,
    input  logic                                clear_overflow,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [CW-1:0]                       out_channel,
    output logic signed [TIME_WIDTH-1:0]        out_start,
    output logic signed [TIME_WIDTH-1:0]        out_end,
    output logic                                out_in_range,
    output logic [NUM_CHANNELS-1:0]             overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, ACTIVE} ch_state_t;

    ch_state_t                    state [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]      sig_q;
    logic [NUM_CHANNELS-1:0]      pol_q;
    logic [NUM_CHANNELS-1:0]      acc;
    logic signed [TIME_WIDTH-1:0] start_ts [NUM_CHANNELS];

    logic [NUM_CHANNELS-1:0]      pend_valid;
    logic [NUM_CHANNELS-1:0]      pend_acc;
    logic signed [TIME_WIDTH-1:0] pend_start [NUM_CHANNELS];
    logic signed [TIME_WIDTH-1:0] pend_end   [NUM_CHANNELS];

    logic [NUM_CHANNELS-1:0]      in_range;
    logic [NUM_CHANNELS-1:0]      start_edge;
    logic [NUM_CHANNELS-1:0]      end_edge;
    logic [NUM_CHANNELS-1:0]      grant;
    logic [NUM_CHANNELS-1:0]      ov_set;
    logic                         grant_any;
    logic [CW-1:0]                grant_idx;

    logic [CW-1:0]                mem_ch    [FIFO_DEPTH];
    logic signed [TIME_WIDTH-1:0] mem_start [FIFO_DEPTH];
    logic signed [TIME_WIDTH-1:0] mem_end   [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]        mem_acc;
    logic [AW-1:0]                wr_ptr;
    logic [AW-1:0]                rd_ptr;
    logic [AW:0]                  count;
    logic                         full;
    logic                         pop;
    logic                         space;

    assign out_valid    = (count != '0);
    assign full         = (count == DEPTH_CNT);
    assign pop          = out_valid & out_ready;
    assign space        = ~full | pop;
    assign out_channel  = mem_ch[rd_ptr];
    assign out_start    = mem_start[rd_ptr];
    assign out_end      = mem_end[rd_ptr];
    assign out_in_range = mem_acc[rd_ptr];

    // Per-channel range check and edge detection; polarity comes from the
    // live input while idle and from the latched copy during a pulse.
    always_comb begin
        in_range   = '0;
        start_edge = '0;
        end_edge   = '0;
        ov_set     = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            in_range[i]   = (value_in[i*VALUE_WIDTH +: VALUE_WIDTH] >= range_lo) &&
                            (value_in[i*VALUE_WIDTH +: VALUE_WIDTH] <= range_hi);
            start_edge[i] = (state[i] == IDLE) && (tracked_signal[i] != sig_q[i]) &&
                            (tracked_signal[i] != polarity[i]);
            end_edge[i]   = (state[i] == ACTIVE) && (tracked_signal[i] != sig_q[i]) &&
                            (tracked_signal[i] == pol_q[i]);
            ov_set[i]     = end_edge[i] & pend_valid[i] & ~grant[i];
        end
    end

    // Fixed-priority arbiter: lowest-index pending slot wins when the FIFO has room.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        if (space) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (pend_valid[i] && !grant_any) begin
                    grant[i]  = 1'b1;
                    grant_any = 1'b1;
                    grant_idx = CW'(i);
                end
            end
        end
    end

    // Channel FSMs and pending slots; a slot granted this cycle can take a new record.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q      <= tracked_signal;
            pol_q      <= '0;
            acc        <= '0;
            pend_valid <= '0;
            pend_acc   <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                state[i]      <= IDLE;
                start_ts[i]   <= '0;
                pend_start[i] <= '0;
                pend_end[i]   <= '0;
            end
        end else begin
            sig_q <= tracked_signal;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                case (state[i])
                    IDLE: begin
                        if (start_edge[i]) begin
                            state[i]    <= ACTIVE;
                            pol_q[i]    <= polarity[i];
                            start_ts[i] <= counter;
                            acc[i]      <= in_range[i];
                        end
                    end
                    ACTIVE: begin
                        if (end_edge[i]) state[i] <= IDLE;
                        else             acc[i]   <= acc[i] & in_range[i];
                    end
                    default: state[i] <= IDLE;
                endcase

                if (end_edge[i] && (!pend_valid[i] || grant[i])) begin
                    pend_valid[i] <= 1'b1;
                    pend_start[i] <= start_ts[i];
                    pend_end[i]   <= counter;
                    pend_acc[i]   <= acc[i];
                end else if (grant[i]) begin
                    pend_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Sticky overflow flags; a drop in the same cycle as a clear keeps its bit set.
    always_ff @(posedge clk) begin
        if (rst) overflow <= '0;
        else     overflow <= (clear_overflow ? '0 : overflow) | ov_set;
    end

    // Shared record FIFO, one push and one pop per cycle at most.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            mem_acc <= '0;
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                mem_ch[j]    <= '0;
                mem_start[j] <= '0;
                mem_end[j]   <= '0;
            end
        end else begin
            if (grant_any) begin
                mem_ch[wr_ptr]    <= grant_idx;
                mem_start[wr_ptr] <= pend_start[grant_idx];
                mem_end[wr_ptr]   <= pend_end[grant_idx];
                mem_acc[wr_ptr]   <= pend_acc[grant_idx];
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({grant_any, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_signal_tracker.sv
// Directed bench for multi_signal_tracker with a queue scoreboard: stimulus
// pushes hand-computed records, a negedge monitor pops on each handshake.
module tb_multi_signal_tracker;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [31:0] counter;
    logic [3:0]         tracked_signal;
    logic [3:0]         polarity;
    logic [127:0]       value_in;
    logic [31:0]        range_lo;
    logic [31:0]        range_hi;
    logic               clear_overflow;
    logic               out_valid;
    logic               out_ready;
    logic [1:0]         out_channel;
    logic signed [31:0] out_start;
    logic signed [31:0] out_end;
    logic               out_in_range;
    logic [3:0]         overflow;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0]  ch;
        logic [31:0] st;
        logic [31:0] en;
        logic        ir;
    } rec_t;

    rec_t exp_q[$];

    multi_signal_tracker dut (
        .clk(clk), .rst(rst), .counter(counter), .tracked_signal(tracked_signal),
        .polarity(polarity), .value_in(value_in), .range_lo(range_lo),
        .range_hi(range_hi), .clear_overflow(clear_overflow), .out_valid(out_valid),
        .out_ready(out_ready), .out_channel(out_channel), .out_start(out_start),
        .out_end(out_end), .out_in_range(out_in_range), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Monitor: every accepted head record is compared with the oldest expectation.
    always @(negedge clk) begin
        rec_t got;
        rec_t want;
        if (!rst && out_valid && out_ready) begin
            got = {out_channel, out_start, out_end, out_in_range};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL record_unexpected got=%h required=none", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    bad++;
                    $display("FAIL record got ch=%0d st=%h en=%h ir=%0d required ch=%0d st=%h en=%h ir=%0d",
                             got.ch, got.st, got.en, got.ir, want.ch, want.st, want.en, want.ir);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        counter = counter + 32'sd1;
    endtask

    task automatic goto(input logic [31:0] target);
        for (int n = 0; n < 1000 && counter != target; n++) step();
        if (counter != target) begin
            $display("FAIL goto_timeout got=%h required=%h", counter, target);
            $fatal(1, "counter never reached target");
        end
    endtask

    task automatic expect_rec(input logic [1:0] ch, input logic [31:0] st,
                              input logic [31:0] en, input logic ir);
        rec_t r;
        r = {ch, st, en, ir};
        exp_q.push_back(r);
    endtask

    task automatic set_val(input int ch, input logic [31:0] v);
        value_in[ch*32 +: 32] = v;
    endtask

    initial begin
        rst = 1'b1;
        counter = 0;
        tracked_signal = '0;
        polarity = '0;
        value_in = {4{32'd2}};
        range_lo = 32'd1;
        range_hi = 32'd3;
        clear_overflow = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        chk("reset_out_start", 64'(out_start), 64'd0);
        rst = 1'b0;
        counter = 0;

        // basic high pulse and latency
        goto(5);  tracked_signal[0] = 1'b1;
        goto(9);  tracked_signal[0] = 1'b0;
        expect_rec(2'd0, 32'd5, 32'd9, 1'b1);
        step();
        chk("latency_k", 64'(out_valid), 64'd0);
        step();
        chk("latency_k1", 64'(out_valid), 64'd1);

        // out-of-range mid pulse, then out-of-range only on the end cycle
        goto(15); tracked_signal[0] = 1'b1;
        goto(17); set_val(0, 32'd8);
        goto(18); set_val(0, 32'd2);
        goto(19); tracked_signal[0] = 1'b0;
        expect_rec(2'd0, 32'd15, 32'd19, 1'b0);
        goto(22); tracked_signal[0] = 1'b1;
        goto(25); tracked_signal[0] = 1'b0; set_val(0, 32'd8);
        expect_rec(2'd0, 32'd22, 32'd25, 1'b1);
        goto(26); set_val(0, 32'd2);

        // low pulse with polarity flipped mid pulse
        goto(28); polarity[1] = 1'b1; tracked_signal[1] = 1'b1;
        goto(30); tracked_signal[1] = 1'b0;
        goto(31); polarity[1] = 1'b0;
        goto(32); tracked_signal[1] = 1'b1;
        expect_rec(2'd1, 32'd30, 32'd32, 1'b1);
        goto(34); tracked_signal[1] = 1'b0;

        // backpressure, ordering, overflow
        goto(44); out_ready = 1'b0;
        goto(45); tracked_signal = 4'b1111;
        goto(50); tracked_signal = 4'b0000;
        for (int c = 0; c < 4; c++) expect_rec(2'(c), 32'd45, 32'd50, 1'b1);
        goto(53); tracked_signal[0] = 1'b1;
        goto(55); tracked_signal[0] = 1'b0;
        expect_rec(2'd0, 32'd53, 32'd55, 1'b1);
        goto(57); tracked_signal[0] = 1'b1;
        goto(59); tracked_signal[0] = 1'b0;
        chk("overflow_before_drop", 64'(overflow), 64'd0);
        goto(60);
        chk("overflow_after_drop", 64'(overflow), 64'h1);
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_channel", 64'(out_channel), 64'd0);
        chk("hold_start", 64'(out_start), 64'd45);
        goto(63); tracked_signal[0] = 1'b1;
        goto(65); tracked_signal[0] = 1'b0; clear_overflow = 1'b1;
        goto(66); clear_overflow = 1'b0;
        chk("overflow_set_beats_clear", 64'(overflow), 64'h1);
        goto(67); clear_overflow = 1'b1;
        goto(68); clear_overflow = 1'b0;
        chk("overflow_cleared", 64'(overflow), 64'd0);
        goto(70); out_ready = 1'b1;

        // reset mid pulse
        goto(80); tracked_signal[2] = 1'b1;
        goto(83); rst = 1'b1;
        goto(85); rst = 1'b0;
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_queue_empty", 64'(exp_q.size()), 64'd0);
        goto(88); tracked_signal[2] = 1'b0;
        goto(90); tracked_signal[2] = 1'b1;
        goto(92); tracked_signal[2] = 1'b0;
        expect_rec(2'd2, 32'd90, 32'd92, 1'b1);

        // counter wrap across a pulse
        goto(96); counter = 32'sh7FFFFFFE;
        goto(32'h7FFFFFFF); tracked_signal[3] = 1'b1;
        goto(32'h80000001); tracked_signal[3] = 1'b0;
        expect_rec(2'd3, 32'h7FFFFFFF, 32'h80000001, 1'b1);

        // inverted range never matches; inclusive bounds do
        goto(32'h80000004); counter = 200;
        range_lo = 32'd5; range_hi = 32'd3; set_val(0, 32'd4);
        goto(202); tracked_signal[0] = 1'b1;
        goto(204); tracked_signal[0] = 1'b0;
        expect_rec(2'd0, 32'd202, 32'd204, 1'b0);
        goto(206); range_lo = 32'd1; range_hi = 32'd3;
        set_val(0, 32'd3); set_val(1, 32'd1);
        goto(208); tracked_signal[1:0] = 2'b11;
        goto(210); tracked_signal[1:0] = 2'b00;
        expect_rec(2'd0, 32'd208, 32'd210, 1'b1);
        expect_rec(2'd1, 32'd208, 32'd210, 1'b1);

        for (int w = 0; w < 200 && exp_q.size() != 0; w++) step();
        step();
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_out_valid", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
